aes_round_seq: RTL
==================

# aes_round_seq

Parametrised AES round sequencer: the next generation of the cipher control FSM. It drives the datapath state code `cs`, the round counter and the round-key index for encryption and decryption at all three key lengths (10/12/14 rounds). It runs an optional decrypt key-expansion phase, which it skips when the cached schedule is still valid, and exposes a start/done/ack handshake plus abort. It sits between the host interface and the shared AES datapath/key-schedule blocks.

## Interface
- CNT_W, 4: width of `rnd`/`key_idx`; must be ≥4.
- KEY_CACHE, 1: 1 allows a decrypt to skip INV on a cache hit; 0 makes every decrypt run INV.
- FIN_HOLD, 1: 1 holds FIN until `ack`; 0 makes FIN last exactly one cycle.

- clk  in  1  clock, all state changes on posedge.
- res  in  1  synchronous, active-low reset.
- start  in  1  request; sampled only in RES.
- mode  in  1  0 = encrypt, 1 = decrypt; latched on start accept.
- klen  in  2  00 = 128 (Nr 10), 01 = 192 (Nr 12), 10 = 256 (Nr 14), 11 = illegal; latched on accept.
- new_key  in  1  key changed since the last run; sampled on start.
- abort  in  1  cancel the operation in progress.
- ack  in  1  releases FIN when FIN_HOLD=1.
- cs  out  3  state code: RES 000, STL 001, ADD 010, SUB 011, SHI 100, MIX 101, INV 110, FIN 111.
- rnd  out  CNT_W  round number, or expansion step while in INV.
- key_idx  out  CNT_W  round-key index for ADD: encrypt = rnd, decrypt = Nr − rnd.
- busy  out  1  cs ∉ {RES, FIN}.
- done  out  1  cs == FIN.
- err  out  1  one-cycle pulse on a rejected start.
- key_vld  out  1  decrypt schedule is cached and valid.

## Operation
- **Reset:** `res`=0 at a posedge forces cs=RES, rnd=0, key_vld=0, err=0, latched mode=0, latched Nr=10. Consequently key_idx=0, busy=0, done=0. Reset overrides every other input.
- **RES, start=1, klen=11:** stay in RES, err=1 for one cycle, nothing latched.
- **RES, start=1, legal klen:** latch mode and Nr. Cache hit = key_vld & ~new_key & (klen == cached klen) & KEY_CACHE.
  - new_key=1 clears key_vld.
  - Decrypt without a cache hit: go to INV with rnd=0.
  - Otherwise: go to STL.
- **INV:** rnd increments each cycle. When rnd == Nr−1, go to STL, clear rnd to 0, set key_vld=1 and cache klen.
- **STL:** one cycle, then ADD (round 0, rnd=0).
- **Encrypt round r = 1..Nr:** SUB → SHI → MIX → ADD. MIX is omitted when r == Nr (SHI → ADD).
- **Decrypt round r = 1..Nr:** SHI → SUB → ADD → MIX. MIX is omitted when r == Nr.
- **Round counting:** rnd increments on the transition into the first state of a round (ADD→SUB for encrypt, ADD/MIX→SHI for decrypt).
- **End of run:** ADD with rnd == Nr goes to FIN.
- **FIN:** with FIN_HOLD=1, stay until ack=1, then RES. With FIN_HOLD=0, go to RES after one cycle and ignore ack. rnd holds Nr in FIN and is cleared on the return to RES.
- **Abort:** abort=1 in any state other than RES/FIN goes to RES next cycle with rnd=0. An abort during INV leaves key_vld=0.
- **Ignored inputs:**
  - abort in RES or FIN.
  - start while not in RES.
  - ack outside FIN.
- **Simultaneous inputs:** abort and ack together in FIN go to RES. start in FIN is ignored; a new run needs a return to RES first.
- **Width rules:** key_idx arithmetic is CNT_W bits, unsigned, with no wrap for legal Nr. rnd never exceeds Nr.

## Timing
- All outputs are registered or decoded from registered cs/rnd. There are no combinational input→output paths.
- Start accepted at edge 0. Encrypt, or decrypt with a cache hit:
  - STL at cycle 1, ADD at cycle 2.
  - Rounds 1..Nr−1 take 4 cycles each; round Nr takes 3.
  - FIN at cycle 4·Nr+2: 42 for Nr 10, 50 for Nr 12, 58 for Nr 14.
- Decrypt with expansion adds Nr cycles: FIN at cycle 5·Nr+2 (52 for Nr 10).
- Abort latency: 1 cycle to RES.
- ack latency: 1 cycle FIN→RES. The earliest next accept is the cycle after RES is reached.

## Test plan
- Reset, encrypt klen=00: cs sequence 001,010, then (011,100,101,010)×9, then 011,100,010; done=1 at cycle 42; key_idx == rnd throughout.
- Decrypt klen=10, new_key=1: INV for 14 cycles (rnd 0..13), key_vld rises entering STL, FIN at cycle 72; key_idx=14 at round-0 ADD and 0 at the final ADD.
- Repeat decrypt klen=10, new_key=0: no INV, FIN at cycle 58. Then decrypt klen=00: INV re-runs because klen differs.
- start with klen=11: err pulses 1 cycle, cs stays 000. start during busy: ignored.
- abort at INV step 5: cs=000 next cycle, rnd=0, key_vld=0. res=0 mid-round: all outputs at reset values next edge.
- FIN_HOLD=1: done held 20 cycles until ack, RES next cycle. FIN_HOLD=0: done high exactly one cycle.

Source files
------------

// File: rtl/aes_round_seq.sv
// AES round sequencer: steps the shared datapath through INV/STL/ADD/SUB/SHI/MIX/FIN
// for encrypt and decrypt at 128/192/256-bit keys, caching the decrypt key schedule.
module aes_round_seq #(
  parameter int CNT_W     = 4,
  parameter bit KEY_CACHE = 1'b1,
  parameter bit FIN_HOLD  = 1'b1
) (
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  input  logic             mode,
  input  logic [1:0]       klen,
  input  logic             new_key,
  input  logic             abort,
  input  logic             ack,
  output logic [2:0]       cs,
  output logic [CNT_W-1:0] rnd,
  output logic [CNT_W-1:0] key_idx,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             key_vld
);

  typedef enum logic [2:0] {
    S_RES = 3'b000,
    S_STL = 3'b001,
    S_ADD = 3'b010,
    S_SUB = 3'b011,
    S_SHI = 3'b100,
    S_MIX = 3'b101,
    S_INV = 3'b110,
    S_FIN = 3'b111
  } state_t;

  state_t           r_cs, w_cs_nxt;
  logic [CNT_W-1:0] r_rnd, w_rnd_nxt;
  logic [CNT_W-1:0] r_nr, w_nr_nxt;
  logic             r_mode, w_mode_nxt;
  logic [1:0]       r_klen, w_klen_nxt;
  logic [1:0]       r_kcache, w_kcache_nxt;
  logic             r_key_vld, w_key_vld_nxt;
  logic             r_err, w_err_nxt;
  logic             w_hit;
  logic [CNT_W-1:0] w_rnd_inc;

  function automatic logic [CNT_W-1:0] nr_of(input logic [1:0] k);
    logic [CNT_W-1:0] v;
    case (k)
      2'b00:   v = CNT_W'(4'd10);
      2'b01:   v = CNT_W'(4'd12);
      2'b10:   v = CNT_W'(4'd14);
      default: v = CNT_W'(4'd10);
    endcase
    return v;
  endfunction

  assign w_rnd_inc = r_rnd + CNT_W'(1'b1);

  // A cached schedule is reusable only for the same key length and an unchanged key.
  always_comb begin
    w_hit = r_key_vld & ~new_key & (klen == r_kcache) & KEY_CACHE;
  end

  // Next-state, counter and latch logic.
  always_comb begin
    w_cs_nxt      = r_cs;
    w_rnd_nxt     = r_rnd;
    w_nr_nxt      = r_nr;
    w_mode_nxt    = r_mode;
    w_klen_nxt    = r_klen;
    w_kcache_nxt  = r_kcache;
    w_key_vld_nxt = r_key_vld;
    w_err_nxt     = 1'b0;
    if (abort && (r_cs != S_RES) && (r_cs != S_FIN)) begin
      w_cs_nxt  = S_RES;
      w_rnd_nxt = CNT_W'(1'b0);
    end else begin
      case (r_cs)
        S_RES: begin
          w_rnd_nxt = CNT_W'(1'b0);
          if (start) begin
            if (klen == 2'b11) begin
              w_err_nxt = 1'b1;
            end else begin
              w_mode_nxt = mode;
              w_nr_nxt   = nr_of(klen);
              w_klen_nxt = klen;
              if (new_key) begin
                w_key_vld_nxt = 1'b0;
              end else begin
                w_key_vld_nxt = r_key_vld;
              end
              // Expansion invalidates the old schedule until it completes.
              if (mode && !w_hit) begin
                w_cs_nxt      = S_INV;
                w_key_vld_nxt = 1'b0;
              end else begin
                w_cs_nxt = S_STL;
              end
            end
          end else begin
            w_cs_nxt = S_RES;
          end
        end
        S_INV: begin
          if (r_rnd == (r_nr - CNT_W'(1'b1))) begin
            w_cs_nxt      = S_STL;
            w_rnd_nxt     = CNT_W'(1'b0);
            w_key_vld_nxt = 1'b1;
            w_kcache_nxt  = r_klen;
          end else begin
            w_rnd_nxt = w_rnd_inc;
          end
        end
        S_STL: begin
          w_cs_nxt  = S_ADD;
          w_rnd_nxt = CNT_W'(1'b0);
        end
        S_ADD: begin
          if (r_rnd == r_nr) begin
            w_cs_nxt = S_FIN;
          end else if (!r_mode) begin
            w_cs_nxt  = S_SUB;
            w_rnd_nxt = w_rnd_inc;
          end else if (r_rnd == CNT_W'(1'b0)) begin
            w_cs_nxt  = S_SHI;
            w_rnd_nxt = w_rnd_inc;
          end else begin
            w_cs_nxt = S_MIX;
          end
        end
        S_SUB: begin
          if (!r_mode) begin
            w_cs_nxt = S_SHI;
          end else begin
            w_cs_nxt = S_ADD;
          end
        end
        S_SHI: begin
          if (r_mode) begin
            w_cs_nxt = S_SUB;
          end else if (r_rnd == r_nr) begin
            w_cs_nxt = S_ADD;
          end else begin
            w_cs_nxt = S_MIX;
          end
        end
        S_MIX: begin
          if (r_mode) begin
            w_cs_nxt  = S_SHI;
            w_rnd_nxt = w_rnd_inc;
          end else begin
            w_cs_nxt = S_ADD;
          end
        end
        S_FIN: begin
          if (!FIN_HOLD || ack) begin
            w_cs_nxt  = S_RES;
            w_rnd_nxt = CNT_W'(1'b0);
          end else begin
            w_cs_nxt = S_FIN;
          end
        end
        default: begin
          w_cs_nxt  = S_RES;
          w_rnd_nxt = CNT_W'(1'b0);
        end
      endcase
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!res) begin
      r_cs      <= S_RES;
      r_rnd     <= CNT_W'(1'b0);
      r_nr      <= CNT_W'(4'd10);
      r_mode    <= 1'b0;
      r_klen    <= 2'b00;
      r_kcache  <= 2'b00;
      r_key_vld <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_cs      <= w_cs_nxt;
      r_rnd     <= w_rnd_nxt;
      r_nr      <= w_nr_nxt;
      r_mode    <= w_mode_nxt;
      r_klen    <= w_klen_nxt;
      r_kcache  <= w_kcache_nxt;
      r_key_vld <= w_key_vld_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign cs      = r_cs;
  assign rnd     = r_rnd;
  assign key_idx = r_mode ? (r_nr - r_rnd) : r_rnd;
  assign busy    = (r_cs != S_RES) && (r_cs != S_FIN);
  assign done    = (r_cs == S_FIN);
  assign err     = r_err;
  assign key_vld = r_key_vld;

endmodule
